// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between two byte sources,
// sending each source's latest value on change with round-robin arbitration.
module uart_tx_scheduler #(
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] src0_data,
    input  logic [7:0] src1_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic [1:0] pend,
    output logic [7:0] coalesce_cnt,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
    localparam logic [15:0] TIMER_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_reg;
    logic        rr_reg;
    logic        sel_reg;
    logic [15:0] timer_reg;
    logic [7:0]  saved_reg;
    logic [7:0]  src_data  [2];
    logic [7:0]  sent_reg  [2];
    logic [7:0]  sent_next [2];
    logic [7:0]  prev_reg  [2];
    logic [1:0]  pend_next;
    logic [1:0]  coal_ev;
    logic        launch;
    logic        timeout_hit;
    logic        pick;
    logic [8:0]  coal_sum;
    logic [7:0]  coal_next;

    assign src_data[0] = src0_data;
    assign src_data[1] = src1_data;

    assign launch      = (state_reg == IDLE) && (pend != 2'b00) && !tx_busy;
    assign timeout_hit = (state_reg == WAIT_BUSY) && !tx_busy && (timer_reg == TIMER_LAST);
    // With both pending, serve the source that was not served last.
    assign pick = (pend == 2'b11) ? ~rr_reg : pend[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // A timed-out launch rolls sent back so the source re-pends and retries.
            assign sent_next[gi] = (launch && (pick == 1'(gi)))         ? src_data[gi] :
                                   (timeout_hit && (sel_reg == 1'(gi))) ? saved_reg    :
                                                                          sent_reg[gi];
            assign pend_next[gi] = (src_data[gi] != sent_next[gi]);
            assign coal_ev[gi]   = (src_data[gi] != prev_reg[gi]) && pend[gi];
        end
    endgenerate

    assign coal_sum  = {1'b0, coalesce_cnt} + {8'd0, coal_ev[0]} + {8'd0, coal_ev[1]};
    assign coal_next = coal_sum[8] ? 8'hFF : coal_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sent_reg[i] <= '0;
                prev_reg[i] <= '0;
            end
            pend         <= '0;
            coalesce_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sent_reg[i] <= sent_next[i];
                prev_reg[i] <= src_data[i];
            end
            pend         <= pend_next;
            coalesce_cnt <= coal_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rr_reg      <= 1'b1;
            sel_reg     <= 1'b0;
            timer_reg   <= '0;
            saved_reg   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        sel_reg   <= pick;
                        saved_reg <= sent_reg[pick];
                        tx_data   <= src_data[pick];
                        grant     <= pick ? 2'b10 : 2'b01;
                        tx_start  <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_reg <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        rr_reg      <= sel_reg;
                        state_reg   <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant     <= '0;
                        rr_reg    <= sel_reg;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler; the transmitter's busy
// handshake is driven by hand, cycle by cycle.
module tb_uart_tx_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] src0_data = 8'd0;
    logic [7:0] src1_data = 8'd0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic [1:0] pend;
    logic [7:0] coalesce_cnt;
    logic       timeout_err;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;
    int viol = 0;
    int s0 = 0;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.ACK_TIMEOUT(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src0_data    (src0_data),
        .src1_data    (src1_data),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .grant        (grant),
        .pend         (pend),
        .coalesce_cnt (coalesce_cnt),
        .timeout_err  (timeout_err)
    );

    // Pulse counting and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start === 1'b1) start_cnt++;
        if ((tx_start === 1'b1 && prev_start === 1'b1) || grant === 2'b11) viol++;
        prev_start = tx_start;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_pend", pend, 0);
        chk("rst_coalesce", coalesce_cnt, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_no_pend", pend, 0);
        chk("post_rst_no_start", tx_start, 0);

        // Single send: src0 0 -> 5
        src0_data = 8'd5;
        tick(1);
        chk("single_pend", pend, 2'b01);
        chk("single_no_start_yet", tx_start, 0);
        tick(1);
        chk("single_start", tx_start, 1);
        chk("single_data", tx_data, 8'd5);
        chk("single_grant", grant, 2'b01);
        tick(1);
        chk("single_start_one_cycle", tx_start, 0);
        tx_busy = 1'b1;
        tick(4);
        tx_busy = 1'b0;
        tick(1);
        chk("single_end_grant", grant, 0);
        chk("single_end_pend", pend, 0);
        $display("single send: byte 05 via source 0");

        // Arbitration after reset
        rst_n = 1'b0; src0_data = 8'd0;
        tick(1);
        rst_n = 1'b1;
        s0 = start_cnt;
        src0_data = 8'd3; src1_data = 8'd9;
        tick(1);
        chk("arb_pend_both", pend, 2'b11);
        tick(1);
        chk("arb_first_start", tx_start, 1);
        chk("arb_first_data", tx_data, 8'd3);
        chk("arb_first_grant", grant, 2'b01);
        tick(1); tx_busy = 1'b1;
        tick(1); tx_busy = 1'b0;
        tick(1);
        chk("arb_mid_grant", grant, 0);
        chk("arb_mid_pend", pend, 2'b10);
        tick(1);
        chk("arb_second_start", tx_start, 1);
        chk("arb_second_data", tx_data, 8'd9);
        chk("arb_second_grant", grant, 2'b10);
        tick(1); tx_busy = 1'b1;
        tick(1); tx_busy = 1'b0;
        tick(3);
        chk("arb_end_pend", pend, 0);
        chk("arb_start_count", start_cnt - s0, 2);
        $display("arbitration: bytes 03 then 09");

        // Coalescing
        rst_n = 1'b0; src0_data = 8'd0; src1_data = 8'd0;
        tick(1);
        rst_n = 1'b1;
        s0 = start_cnt;
        src0_data = 8'd5;
        tick(2);
        chk("coal_first_data", tx_data, 8'd5);
        tick(1); tx_busy = 1'b1;
        tick(1);
        src0_data = 8'd6; tick(1);
        src0_data = 8'd7; tick(1);
        src0_data = 8'd8; tick(1);
        src0_data = 8'd9; tick(1);
        chk("coal_count", coalesce_cnt, 8'd3);
        chk("coal_data_held", tx_data, 8'd5);
        chk("coal_pend", pend, 2'b01);
        tx_busy = 1'b0;
        tick(1);
        chk("coal_idle_grant", grant, 0);
        tick(1);
        chk("coal_followup_start", tx_start, 1);
        chk("coal_followup_data", tx_data, 8'd9);
        chk("coal_followup_grant", grant, 2'b01);
        tick(1); tx_busy = 1'b1;
        tick(1); tx_busy = 1'b0;
        tick(1);
        chk("coal_end_pend", pend, 0);
        chk("coal_start_count", start_cnt - s0, 2);
        $display("coalescing: 05 sent, then 09 after 3 collapsed updates");

        // Change-and-revert on src1 while serving src0
        s0 = start_cnt;
        src0_data = 8'd1;
        tick(2);
        chk("rev_start", tx_start, 1);
        tick(1); tx_busy = 1'b1;
        tick(1);
        src1_data = 8'd4; tick(1);
        chk("rev_pend_set", pend, 2'b10);
        src1_data = 8'd0; tick(1);
        chk("rev_pend_clear", pend, 0);
        tx_busy = 1'b0;
        tick(4);
        chk("rev_start_count", start_cnt - s0, 1);
        chk("rev_end_pend", pend, 0);
        chk("rev_coalesce", coalesce_cnt, 8'd4);
        $display("change-and-revert: src1 not sent");

        // Handshake timeout and retry
        src0_data = 8'h5A;
        tick(2);
        chk("to_start", tx_start, 1);
        chk("to_data", tx_data, 8'h5A);
        tick(10);
        chk("to_not_yet", timeout_err, 0);
        chk("to_grant_held", grant, 2'b01);
        tick(1);
        chk("to_err_set", timeout_err, 1);
        chk("to_grant_clear", grant, 0);
        chk("to_repend", pend, 2'b01);
        tick(1);
        chk("to_retry_start", tx_start, 1);
        chk("to_retry_data", tx_data, 8'h5A);
        chk("to_retry_grant", grant, 2'b01);
        tick(1); tx_busy = 1'b1;
        tick(1); tx_busy = 1'b0;
        tick(1);
        chk("to_end_grant", grant, 0);
        chk("to_err_sticky", timeout_err, 1);
        chk("to_end_pend", pend, 0);
        $display("timeout: byte 5a retried");

        // Mid-transfer reset in WAIT_DONE
        src0_data = 8'h22;
        tick(2);
        chk("mr_start", tx_start, 1);
        tick(1); tx_busy = 1'b1;
        tick(1);
        rst_n = 1'b0; src0_data = 8'd0; src1_data = 8'd0; tx_busy = 1'b0;
        #1;
        chk("mr_tx_start", tx_start, 0);
        chk("mr_tx_data", tx_data, 0);
        chk("mr_grant", grant, 0);
        chk("mr_pend", pend, 0);
        chk("mr_coalesce", coalesce_cnt, 0);
        chk("mr_timeout", timeout_err, 0);
        tick(1);
        rst_n = 1'b1;
        s0 = start_cnt;
        tick(4);
        chk("mr_no_send", start_cnt - s0, 0);
        chk("mr_end_pend", pend, 0);
        $display("mid-transfer reset: aborted, no resend");

        chk("no_double_start_or_grant11", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
